// File: rtl/alu_pkg.sv
// Shared opcode encoding and data width for the ALU datapath.
package definitions;

    localparam int DW = 8;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        LSH  = 4'd2,
        RSH  = 4'd3,
        MOV  = 4'd4,
        XOR  = 4'd5,
        AND  = 4'd6,
        OR   = 4'd7,
        BGE  = 4'd8,
        BNE  = 4'd9,
        RXOR = 4'd10,
        BEQ  = 4'd11
    } op_mne;

endpackage

// File: rtl/alu_comb.sv
// Opcode decode and datapath producing the next result and branch flag.
module alu_comb
    import definitions::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [DW-1:0] result,
    output logic          branch
);

    always_comb begin
        result = '0;
        branch = 1'b0;
        // Unlisted or unknown opcodes fall through to zero result, no branch.
        case (op)
            ADD:  result = a + b;
            SUB:  result = a - b;
            LSH:  result = a << b[2:0];
            RSH:  result = a >> b[2:0];
            MOV:  result = b;
            XOR:  result = a ^ b;
            AND:  result = a & b;
            OR:   result = a | b;
            BGE:  branch = (a >= b);
            BNE:  branch = (a != b);
            RXOR: result = {{(DW-1){1'b0}}, ^a};
            BEQ:  branch = (a == b);
            default: begin
                result = '0;
                branch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU top: combinational datapath followed by a reset-cleared output register.
module alu
    import definitions::*;
(
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [DW-1:0] InputA,
    input  logic [DW-1:0] InputB,
    input  logic [3:0]    OP,
    output logic [DW-1:0] Out,
    output logic          BranchFlag
);

    logic [DW-1:0] result;
    logic          branch;

    alu_comb u_comb (
        .a      (InputA),
        .b      (InputB),
        .op     (OP),
        .result (result),
        .branch (branch)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out        <= '0;
            BranchFlag <= 1'b0;
        end else begin
            Out        <= result;
            BranchFlag <= branch;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench: directed vectors queue expectations, a monitor checks them.
module tb_alu;
    import definitions::*;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [3:0] OP;
    logic [7:0] Out;
    logic       BranchFlag;

    typedef struct {
        int         due;
        logic [7:0] out;
        logic       flag;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   failures;

    alu dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .InputA     (InputA),
        .InputB     (InputB),
        .OP         (OP),
        .Out        (Out),
        .BranchFlag (BranchFlag)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial cyc = 0;
    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (Out !== e.out || BranchFlag !== e.flag) begin
                failures++;
                $display("FAIL %s: got out=%h flag=%b, want out=%h flag=%b",
                         e.name, Out, BranchFlag, e.out, e.flag);
            end
        end
    end

    task automatic apply(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] eo,
                         input logic ef, input string name);
        exp_t e;
        @(posedge Clk);
        #1;
        InputA = a;
        InputB = b;
        OP     = op;
        e.due  = cyc + 1;
        e.out  = eo;
        e.flag = ef;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic check(input logic [7:0] eo, input logic ef,
                         input string name);
        checks++;
        if (Out !== eo || BranchFlag !== ef) begin
            failures++;
            $display("FAIL %s: got out=%h flag=%b, want out=%h flag=%b",
                     name, Out, BranchFlag, eo, ef);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge Clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s: got pending=%0d, want pending=0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        Reset_n  = 1'b1;
        InputA   = 8'h00;
        InputB   = 8'h00;
        OP       = 4'd0;
        #2 Reset_n = 1'b0;
        #1 check(8'h00, 1'b0, "reset_state");
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        apply(8'h0A, 8'h01, 4'd0,  8'h0B, 1'b0, "add");
        apply(8'h0A, 8'h01, 4'd1,  8'h09, 1'b0, "sub");
        apply(8'h0A, 8'h01, 4'd2,  8'h14, 1'b0, "lsh");
        apply(8'h0A, 8'h01, 4'd3,  8'h05, 1'b0, "rsh");
        apply(8'h0A, 8'h01, 4'd4,  8'h01, 1'b0, "mov");
        apply(8'h0A, 8'h01, 4'd5,  8'h0B, 1'b0, "xor");
        apply(8'h0A, 8'h01, 4'd6,  8'h00, 1'b0, "and");
        apply(8'h0A, 8'h01, 4'd7,  8'h0B, 1'b0, "or");
        apply(8'h0A, 8'h01, 4'd8,  8'h00, 1'b1, "bge");
        apply(8'h0A, 8'h01, 4'd9,  8'h00, 1'b1, "bne");
        apply(8'h0A, 8'h01, 4'd10, 8'h00, 1'b0, "rxor");
        apply(8'h0A, 8'h01, 4'd11, 8'h00, 1'b0, "beq");

        apply(8'hFF, 8'h01, 4'd0,  8'h00, 1'b0, "add_wrap");
        apply(8'h00, 8'h01, 4'd1,  8'hFF, 1'b0, "sub_wrap");
        apply(8'h81, 8'h01, 4'd2,  8'h02, 1'b0, "lsh_81_1");
        apply(8'h81, 8'h07, 4'd3,  8'h01, 1'b0, "rsh_81_7");
        apply(8'h0A, 8'h09, 4'd2,  8'h14, 1'b0, "lsh_b09");
        apply(8'hA5, 8'h00, 4'd2,  8'hA5, 1'b0, "lsh_by0");
        apply(8'hA5, 8'h00, 4'd3,  8'hA5, 1'b0, "rsh_by0");

        apply(8'h5A, 8'h5A, 4'd8,  8'h00, 1'b1, "bge_eq");
        apply(8'h5A, 8'h5A, 4'd9,  8'h00, 1'b0, "bne_eq");
        apply(8'h5A, 8'h5A, 4'd11, 8'h00, 1'b1, "beq_eq");
        apply(8'h00, 8'hFF, 4'd8,  8'h00, 1'b0, "bge_lt");
        apply(8'h00, 8'hFF, 4'd9,  8'h00, 1'b1, "bne_ne");
        apply(8'h00, 8'hFF, 4'd11, 8'h00, 1'b0, "beq_ne");

        apply(8'h07, 8'h01, 4'd10, 8'h01, 1'b0, "rxor_07");
        apply(8'hFF, 8'h01, 4'd10, 8'h00, 1'b0, "rxor_ff");
        apply(8'h0A, 8'h01, 4'd12, 8'h00, 1'b0, "op12");
        apply(8'h0A, 8'h01, 4'd13, 8'h00, 1'b0, "op13");
        apply(8'h0A, 8'h01, 4'd14, 8'h00, 1'b0, "op14");
        apply(8'h0A, 8'h01, 4'd15, 8'h00, 1'b0, "op15");

        apply(8'h0A, 8'h01, 4'd0,  8'h0B, 1'b0, "lat_first");
        apply(8'h33, 8'h55, 4'd4,  8'h55, 1'b0, "lat_second");
        #3 check(8'h0B, 1'b0, "latency_hold");
        drain("drain_main");

        apply(8'h0A, 8'h01, 4'd0,  8'h0B, 1'b0, "pre_reset");
        drain("drain_pre_reset");
        #2 Reset_n = 1'b0;
        #1 check(8'h00, 1'b0, "reset_async");
        @(posedge Clk);
        @(posedge Clk);
        #1 check(8'h00, 1'b0, "reset_held");
        @(negedge Clk);
        Reset_n = 1'b1;
        #1 check(8'h00, 1'b0, "release_no_edge");
        @(posedge Clk);
        #1 check(8'h0B, 1'b0, "release_first_edge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
